// File: rtl/fw_ip_pkg.sv
// Shared types and constants for the fw_ip configuration-scan blocks.
package fw_ip_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        LOAD = 2'd3
    } cfg_seq_state_t;

    localparam int CFG_WORD_W = 24;

    localparam int STAT_BUSY     = 31;
    localparam int STAT_DONE     = 30;
    localparam int STAT_ABORTED  = 29;
    localparam int STAT_ERR_BUSY = 28;
    localparam int STAT_CNT_W    = 16;

endpackage

// File: rtl/fw_phase_timer.sv
// Phase timer: counts CLK_DIV fw_clk cycles per sequencer phase and flags the last one.
module fw_phase_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic fw_clk,
    input  logic fw_rst,
    input  logic restart,
    input  logic clear,
    output logic phase_last
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign phase_last = (cnt_q == CW'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || clear || phase_last) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge fw_clk) begin
        if (fw_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fw_cfg_shift_sequencer.sv
// FW-side scan-chain sequencer: shifts SW config words into the DUT chain with a generated
// cfg_clk, pulses cfg_load, and captures cfg_out into a readback buffer.
module fw_cfg_shift_sequencer
    import fw_ip_pkg::*;
#(
    parameter int CFG_WORDS = 32,
    parameter int CLK_DIV   = 4
) (
    input  logic                  fw_clk,
    input  logic                  fw_rst,
    input  logic                  wr_en,
    input  logic [CFG_WORD_W-1:0] wr_data,
    input  logic                  ptr_clr,
    input  logic                  rd_en,
    output logic [CFG_WORD_W-1:0] rd_data,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  status_clear,
    output logic [31:0]           status,
    output logic                  cfg_clk,
    output logic                  cfg_in,
    output logic                  cfg_load,
    input  logic                  cfg_out
);

    localparam int N  = CFG_WORD_W * CFG_WORDS;
    localparam int PW = (CFG_WORDS > 1) ? $clog2(CFG_WORDS) : 1;
    localparam int BW = $clog2(CFG_WORD_W);
    localparam logic [PW-1:0]         PTR_LAST = PW'(CFG_WORDS - 1);
    localparam logic [BW-1:0]         BIT_MSB  = BW'(CFG_WORD_W - 1);
    localparam logic [STAT_CNT_W-1:0] CNT_LAST = STAT_CNT_W'(N - 1);

    if (N > 65536 || CLK_DIV < 1) begin : g_param_check
        $error("fw_cfg_shift_sequencer: chain length must be <= 65536 and CLK_DIV >= 1");
    end

    logic [CFG_WORD_W-1:0] tx_buf [CFG_WORDS];
    logic [CFG_WORD_W-1:0] rx_buf [CFG_WORDS];

    cfg_seq_state_t        state_q, state_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         word_idx_q, word_idx_d;
    logic [BW-1:0]         bit_idx_q, bit_idx_d;
    logic [STAT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CFG_WORD_W-1:0] rd_data_q, rd_data_d;
    logic                  done_q, done_d, aborted_q, aborted_d, err_busy_q, err_busy_d;
    logic                  busy_q, busy_d, cfg_clk_q, cfg_clk_d;
    logic                  cfg_in_q, cfg_in_d, cfg_load_q, cfg_load_d;
    logic                  tx_we, rx_we, phase_last, state_chg, active;

    assign active    = (state_q != IDLE);
    assign state_chg = (state_d != state_q);

    fw_phase_timer #(.CLK_DIV(CLK_DIV)) u_phase_timer (
        .fw_clk     (fw_clk),
        .fw_rst     (fw_rst),
        .restart    (state_chg),
        .clear      (abort),
        .phase_last (phase_last)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        word_idx_d = word_idx_q;
        bit_idx_d  = bit_idx_q;
        cfg_in_d   = cfg_in_q;
        rx_we      = 1'b0;
        done_d     = status_clear ? 1'b0 : done_q;
        aborted_d  = status_clear ? 1'b0 : aborted_q;
        err_busy_d = status_clear ? 1'b0 : err_busy_q;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d    = LOW;
                    bit_cnt_d  = '0;
                    word_idx_d = '0;
                    bit_idx_d  = BIT_MSB;
                    cfg_in_d   = tx_buf[0][CFG_WORD_W-1];
                end
            end
            LOW: begin
                if (phase_last) begin
                    rx_we   = 1'b1;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (phase_last) begin
                    if (bit_cnt_q == CNT_LAST) begin
                        state_d  = LOAD;
                        cfg_in_d = 1'b0;
                    end else begin
                        state_d   = LOW;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_idx_q == '0) begin
                            bit_idx_d  = BIT_MSB;
                            word_idx_d = word_idx_q + 1'b1;
                        end else begin
                            bit_idx_d = bit_idx_q - 1'b1;
                        end
                        cfg_in_d = tx_buf[word_idx_d][bit_idx_d];
                    end
                end
            end
            LOAD: begin
                if (phase_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides whatever the phase logic decided, including a completing LOAD.
        if (active && abort) begin
            state_d   = IDLE;
            cfg_in_d  = 1'b0;
            rx_we     = 1'b0;
            aborted_d = 1'b1;
            done_d    = status_clear ? 1'b0 : done_q;
        end
        if (active && (start || wr_en)) begin
            err_busy_d = 1'b1;
        end

        busy_d     = (state_d != IDLE);
        cfg_clk_d  = (state_d == HIGH);
        cfg_load_d = (state_d == LOAD);
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_data_d = rd_data_q;
        tx_we     = 1'b0;
        if (ptr_clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en && !active) begin
                tx_we    = 1'b1;
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_data_d = rx_buf[rd_ptr_q];
                rd_ptr_d  = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge fw_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (fw_rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            word_idx_q <= '0;
            bit_idx_q  <= '0;
            bit_cnt_q  <= '0;
            rd_data_q  <= '0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            err_busy_q <= 1'b0;
            busy_q     <= 1'b0;
            cfg_clk_q  <= 1'b0;
            cfg_in_q   <= 1'b0;
            cfg_load_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            word_idx_q <= word_idx_d;
            bit_idx_q  <= bit_idx_d;
            bit_cnt_q  <= bit_cnt_d;
            rd_data_q  <= rd_data_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
            err_busy_q <= err_busy_d;
            busy_q     <= busy_d;
            cfg_clk_q  <= cfg_clk_d;
            cfg_in_q   <= cfg_in_d;
            cfg_load_q <= cfg_load_d;
        end
    end

    // NOTE: the buffers are deliberately left out of reset so they can map onto RAM.
    always_ff @(posedge fw_clk) begin
        if (tx_we) begin
            tx_buf[wr_ptr_q] <= wr_data;
        end
        if (rx_we) begin
            rx_buf[word_idx_q][bit_idx_q] <= cfg_out;
        end
    end

    always_comb begin
        status                  = '0;
        status[STAT_BUSY]       = busy_q;
        status[STAT_DONE]       = done_q;
        status[STAT_ABORTED]    = aborted_q;
        status[STAT_ERR_BUSY]   = err_busy_q;
        status[STAT_CNT_W-1:0]  = bit_cnt_q;
    end

    assign rd_data  = rd_data_q;
    assign cfg_clk  = cfg_clk_q;
    assign cfg_in   = cfg_in_q;
    assign cfg_load = cfg_load_q;

endmodule
